instruction_memory: RTL and testbench



---
 rtl/instruction_memory_if.sv | 23 ++
 rtl/instruction_memory.sv | 46 ++++
 tb/tb_instruction_memory.sv | 110 +++++++++++
 3 files changed

// File: rtl/instruction_memory_if.sv
// Fetch/loader bus for the instruction store: a combinational read port and a
// synchronous whole-word write port.
interface instruction_memory_if #(
  parameter int AW = 32
);
  logic [AW-1:0] addr;
  logic [31:0]   instruction;
  logic          misaligned;
  logic          out_of_range;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  modport slave (
    input  addr, we, wr_addr, wr_data,
    output instruction, misaligned, out_of_range
  );

  modport master (
    output addr, we, wr_addr, wr_data,
    input  instruction, misaligned, out_of_range
  );
endinterface

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: combinational fetch, synchronous loader
// writes, and an asynchronous reset that restores the boot program.
module instruction_memory #(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  instruction_memory_if.slave bus_s
);
  localparam int IW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-3:0] rd_widx, wr_widx;
  logic          rd_oor, wr_oor;

  assign rd_widx = bus_s.addr[AW-1:2];
  assign wr_widx = bus_s.wr_addr[AW-1:2];

  // Word index is out of range when any bit above the index field is set.
  generate
    if (AW - 2 > IW) begin : g_range
      assign rd_oor = |rd_widx[AW-3:IW];
      assign wr_oor = |wr_widx[AW-3:IW];
    end else begin : g_norange
      assign rd_oor = 1'b0;
      assign wr_oor = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      mem_q[0] <= 32'h0050_0093;
      mem_q[1] <= 32'h00A0_0113;
      mem_q[2] <= 32'h0020_81B3;
      mem_q[3] <= 32'h0030_2023;
    end else if (bus_s.we && !wr_oor) begin
      mem_q[wr_widx[IW-1:0]] <= bus_s.wr_data;
    end
  end

  assign bus_s.instruction  = rd_oor ? 32'h0 : mem_q[rd_widx[IW-1:0]];
  assign bus_s.misaligned   = |bus_s.addr[1:0];
  assign bus_s.out_of_range = rd_oor;
endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: boot image, flags, writes, async reset.
module tb_instruction_memory;
  localparam int DEPTH = 256;
  localparam int AW    = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  instruction_memory_if #(.AW(AW)) bus ();

  instruction_memory #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_s (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [31:0] exp_i,
                    input logic exp_m, input logic exp_o);
    bus.addr = a;
    #1;
    chk({tag, "_instr"}, bus.instruction, exp_i);
    chk({tag, "_mis"},   {31'h0, bus.misaligned}, {31'h0, exp_m});
    chk({tag, "_oor"},   {31'h0, bus.out_of_range}, {31'h0, exp_o});
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(posedge clk); #1;
    bus.we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.addr = '0; bus.we = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    #12;
    rd("rst_w0", 0, 32'h0050_0093, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    rd("boot0", 0,  32'h0050_0093, 1'b0, 1'b0);
    #9;
    rd("boot1", 4,  32'h00A0_0113, 1'b0, 1'b0);
    #9;
    rd("boot2", 8,  32'h0020_81B3, 1'b0, 1'b0);
    #9;
    rd("boot3", 12, 32'h0030_2023, 1'b0, 1'b0);
    rd("mis6",  6,  32'h00A0_0113, 1'b1, 1'b0);
    rd("oor1024", 1024, 32'h0, 1'b0, 1'b1);
    rd("last1020", 1020, 32'h0, 1'b0, 1'b0);
    rd("both1027", 1027, 32'h0, 1'b1, 1'b1);

    // Same-word read during write: old value before edge, new after.
    @(negedge clk);
    bus.addr = 16; bus.we = 1'b1; bus.wr_addr = 16; bus.wr_data = 32'hDEAD_BEEF;
    #1;
    chk("wr16_before", bus.instruction, 32'h0);
    @(posedge clk); #1;
    chk("wr16_after", bus.instruction, 32'hDEAD_BEEF);
    bus.we = 1'b0;

    // Out-of-range write must not alias onto word 0 or touch anything else.
    wr(1024, 32'hFFFF_FFFF);
    rd("oorwr_w0",  0,    32'h0050_0093, 1'b0, 1'b0);
    rd("oorwr_w4",  16,   32'hDEAD_BEEF, 1'b0, 1'b0);
    rd("oorwr_top", 1020, 32'h0, 1'b0, 1'b0);

    wr(23, 32'hCAFE_F00D);
    rd("miswr_w5", 20, 32'hCAFE_F00D, 1'b0, 1'b0);
    rd("miswr_w6", 24, 32'h0, 1'b0, 1'b0);

    wr(0, 32'h1234_5678);
    rd("ow_w0", 0, 32'h1234_5678, 1'b0, 1'b0);

    // Async reset between edges restores boot image without a clock edge.
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_w0", bus.instruction, 32'h0050_0093);
    rd("arst_w4", 16, 32'h0, 1'b0, 1'b0);
    rd("arst_w5", 20, 32'h0, 1'b0, 1'b0);

    // Writes during reset are ignored.
    wr(8, 32'hAAAA_AAAA);
    rd("rstwr_w2", 8, 32'h0020_81B3, 1'b0, 1'b0);

    // First write accepted on the first rising edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    bus.we = 1'b1; bus.wr_addr = 8; bus.wr_data = 32'h5555_5555;
    @(posedge clk); #1;
    bus.we = 1'b0;
    rd("postrst_w2", 8, 32'h5555_5555, 1'b0, 1'b0);
    rd("postrst_w0", 0, 32'h0050_0093, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
